// File: rtl/mac_pkg.sv
// Shared types and constants for the multiply-accumulate sequencer.
// Build option: MAC_CTRL_SAT_EN selects saturating accumulation in mac_ctrl.
package mac_pkg;

  localparam int unsigned ACC_W = 16;
  localparam int unsigned OP_W  = 8;

  localparam logic [15:0] SAT_VAL = 16'hFFFF;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2,
    StAcc   = 2'd3
  } mac_state_e;

endpackage

// File: rtl/add_share_mux.sv
// Ownership mux for the single shared adder: the sequencer takes it only during
// its accumulate step, otherwise the multiplier's operands pass straight through.
module add_share_mux
  import mac_pkg::*;
#(
  parameter int unsigned W = ACC_W
) (
  input  logic         sel_acc_i,
  input  logic [W-1:0] acc_i,
  input  logic [W-1:0] prod_i,
  input  logic [W-1:0] mul_sum_a_i,
  input  logic [W-1:0] mul_sum_b_i,
  output logic [W-1:0] add_a_o,
  output logic [W-1:0] add_b_o
);

  always_comb begin
    if (sel_acc_i) begin
      add_a_o = acc_i;
      add_b_o = prod_i;
    end else begin
      add_a_o = mul_sum_a_i;
      add_b_o = mul_sum_b_i;
    end
  end

endmodule

// File: rtl/mac_ctrl.sv
// Multiply-accumulate sequencer in front of the 8x8 sequential multiplier.
// Build option: define MAC_CTRL_SAT_EN to saturate the accumulator on carry.
module mac_ctrl #(
  parameter int unsigned ACC_W = mac_pkg::ACC_W,
  parameter int unsigned OP_W  = mac_pkg::OP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  a_i,
  input  logic [OP_W-1:0]  b_i,
  input  logic             last_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [ACC_W-1:0] acc_o,
  output logic             done_o,
  output logic             ovf_o,
  output logic [OP_W-1:0]  mul_a_o,
  output logic [OP_W-1:0]  mul_b_o,
  output logic             mul_start_o,
  input  logic             mul_busy_i,
  input  logic [ACC_W-1:0] mul_result_i,
  input  logic [ACC_W-1:0] mul_sum_a_i,
  input  logic [ACC_W-1:0] mul_sum_b_i,
  output logic [ACC_W-1:0] add_a_o,
  output logic [ACC_W-1:0] add_b_o,
  input  logic [ACC_W-1:0] add_sum_i
);

  import mac_pkg::*;

  mac_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] prod_q, prod_d;
  logic [OP_W-1:0]  mul_a_q, mul_a_d;
  logic [OP_W-1:0]  mul_b_q, mul_b_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             mul_start_q, mul_start_d;
  logic             last_q, last_d;
  logic             first_q, first_d;
  logic             carry;

  // Unsigned wrap of the shared adder shows up as a sum smaller than the old value.
  assign carry = (add_sum_i < acc_q);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    mul_start_d = 1'b0;
    last_d      = last_q;
    first_d     = first_q;

    unique case (state_q)
      StIdle: begin
        if (valid_i) begin
          mul_a_d     = a_i;
          mul_b_d     = b_i;
          last_d      = last_i;
          mul_start_d = 1'b1;
          state_d     = StStart;
          if (first_q) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            first_d = 1'b0;
          end
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        if (!mul_busy_i) begin
          prod_d  = mul_result_i;
          state_d = StAcc;
        end
      end
      StAcc: begin
        acc_d = add_sum_i;
        if (carry) begin
          ovf_d = 1'b1;
`ifdef MAC_CTRL_SAT_EN
          acc_d = SAT_VAL;
`endif
        end
        if (last_q) begin
          done_d  = 1'b1;
          first_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      prod_q      <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      mul_start_q <= 1'b0;
      last_q      <= 1'b0;
      first_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      mul_start_q <= mul_start_d;
      last_q      <= last_d;
      first_q     <= first_d;
    end
  end

  add_share_mux #(
    .W (ACC_W)
  ) u_add_share_mux (
    .sel_acc_i   (state_q == StAcc),
    .acc_i       (acc_q),
    .prod_i      (prod_q),
    .mul_sum_a_i (mul_sum_a_i),
    .mul_sum_b_i (mul_sum_b_i),
    .add_a_o     (add_a_o),
    .add_b_o     (add_b_o)
  );

  assign ready_o     = (state_q == StIdle) && !rst;
  assign acc_o       = acc_q;
  assign ovf_o       = ovf_q;
  assign done_o      = done_q;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign mul_start_o = mul_start_q;

endmodule

// File: tb/tb_mac_ctrl.sv
// Directed bench for mac_ctrl with a behavioural 15-cycle multiplier and adder.
module tb_mac_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a_i, b_i;
  logic        last_i, valid_i;
  logic        ready_o, done_o, ovf_o, mul_start_o, mul_busy_i;
  logic [15:0] acc_o, mul_result_i, mul_sum_a_i, mul_sum_b_i;
  logic [15:0] add_a_o, add_b_o, add_sum_i;
  logic [7:0]  mul_a_o, mul_b_o;

  always #5 clk = ~clk;

  mac_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .a_i          (a_i),
    .b_i          (b_i),
    .last_i       (last_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .acc_o        (acc_o),
    .done_o       (done_o),
    .ovf_o        (ovf_o),
    .mul_a_o      (mul_a_o),
    .mul_b_o      (mul_b_o),
    .mul_start_o  (mul_start_o),
    .mul_busy_i   (mul_busy_i),
    .mul_result_i (mul_result_i),
    .mul_sum_a_i  (mul_sum_a_i),
    .mul_sum_b_i  (mul_sum_b_i),
    .add_a_o      (add_a_o),
    .add_b_o      (add_b_o),
    .add_sum_i    (add_sum_i)
  );

  assign add_sum_i = add_a_o + add_b_o;

  // Multiplier model: busy rises the cycle after start and stays high 15 cycles.
  logic [4:0]  mcnt;
  logic [15:0] mprod;
  always @(posedge clk) begin
    if (rst) begin
      mcnt  <= '0;
      mprod <= '0;
    end else if (mul_start_o) begin
      mcnt  <= 5'd15;
      mprod <= mul_a_o * mul_b_o;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 5'd1;
    end
  end
  assign mul_busy_i   = (mcnt != 0);
  assign mul_result_i = mprod;

  logic [15:0] lfsr;
  always @(posedge clk) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign mul_sum_a_i = lfsr;
  assign mul_sum_b_i = {lfsr[7:0], lfsr[15:8]} ^ 16'h5A5A;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic        seq_start;
  logic [15:0] exp_prev;

  // One pair from transfer (cycle 0) through the visible result (cycle 19).
  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic last,
                           input logic [15:0] exp_acc, input logic exp_ovf);
    logic [15:0] prev;
    logic [15:0] p;
    prev = seq_start ? 16'h0000 : exp_prev;
    p    = 16'(a) * 16'(b);
    @(negedge clk);
    check("done_width", {31'd0, done_o}, 32'd0);
    check("ready_idle", {31'd0, ready_o}, 32'd1);
    a_i = a; b_i = b; last_i = last; valid_i = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      valid_i = 1'b0;
      if (c == 1) begin
        check("mul_start", {31'd0, mul_start_o}, 32'd1);
        check("mul_a", {24'd0, mul_a_o}, {24'd0, a});
        check("mul_b", {24'd0, mul_b_o}, {24'd0, b});
        check("ready_start", {31'd0, ready_o}, 32'd0);
      end
      if (c == 2) check("mul_start_width", {31'd0, mul_start_o}, 32'd0);
      if (c == 10) begin
        check("wait_pass_a", {16'd0, add_a_o}, {16'd0, mul_sum_a_i});
        check("wait_pass_b", {16'd0, add_b_o}, {16'd0, mul_sum_b_i});
        check("ready_wait", {31'd0, ready_o}, 32'd0);
      end
      if (c == 18) begin
        check("acc_add_a", {16'd0, add_a_o}, {16'd0, prev});
        check("acc_add_b", {16'd0, add_b_o}, {16'd0, p});
        check("ready_acc", {31'd0, ready_o}, 32'd0);
      end
      if (c == 19) begin
        check("acc", {16'd0, acc_o}, {16'd0, exp_acc});
        check("ovf", {31'd0, ovf_o}, {31'd0, exp_ovf});
        check("done", {31'd0, done_o}, {31'd0, last});
        check("ready_back", {31'd0, ready_o}, 32'd1);
      end
    end
    exp_prev  = exp_acc;
    seq_start = last;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        last;
    logic [15:0] exp_acc;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int xt[3];
    int xfers;
    int t;

    vecs[0] = '{8'd3,   8'd4,   1'b1, 16'd12,   1'b0};
    vecs[1] = '{8'd2,   8'd3,   1'b0, 16'd6,    1'b0};
    vecs[2] = '{8'd5,   8'd7,   1'b1, 16'd41,   1'b0};
    vecs[3] = '{8'd5,   8'd5,   1'b1, 16'd25,   1'b0};
    vecs[4] = '{8'd255, 8'd255, 1'b0, 16'hFE01, 1'b0};
`ifdef MAC_CTRL_SAT_EN
    vecs[5] = '{8'd255, 8'd255, 1'b1, 16'hFFFF, 1'b1};
`else
    vecs[5] = '{8'd255, 8'd255, 1'b1, 16'hFC02, 1'b1};
`endif
    vecs[6] = '{8'd1,   8'd1,   1'b1, 16'd1,    1'b0};

    rst = 1'b1; a_i = '0; b_i = '0; last_i = 1'b0; valid_i = 1'b0;
    seq_start = 1'b1; exp_prev = '0;
    repeat (3) @(negedge clk);
    check("ready_in_rst", {31'd0, ready_o}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_acc", {16'd0, acc_o}, 32'd0);
    check("rst_ovf", {31'd0, ovf_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_start", {31'd0, mul_start_o}, 32'd0);
    check("rst_mul_ab", {16'd0, mul_a_o, mul_b_o}, 32'd0);
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    check("idle_pass_a", {16'd0, add_a_o}, {16'd0, mul_sum_a_i});

    for (int i = 0; i < 7; i++)
      send_pair(vecs[i].a, vecs[i].b, vecs[i].last, vecs[i].exp_acc, vecs[i].exp_ovf);

    // valid held high across three pairs: each must be taken exactly once.
    @(negedge clk);
    a_i = 8'd1; b_i = 8'd1; last_i = 1'b0; valid_i = 1'b1;
    xfers = 0; t = 0;
    while (t < 100 && xfers < 3) begin
      if (ready_o) begin
        xt[xfers] = t;
        xfers++;
        @(posedge clk);
        #1;
        case (xfers)
          1:       begin a_i = 8'd2; b_i = 8'd2; last_i = 1'b0; end
          2:       begin a_i = 8'd3; b_i = 8'd3; last_i = 1'b1; end
          default: valid_i = 1'b0;
        endcase
      end
      @(negedge clk);
      t++;
    end
    valid_i = 1'b0;
    check("hold_xfers", xfers, 3);
    if (xfers == 3) begin
      check("hold_gap1", xt[1] - xt[0], 19);
      check("hold_gap2", xt[2] - xt[1], 19);
      repeat (18) @(negedge clk);
      check("hold_done", {31'd0, done_o}, 32'd1);
      check("hold_acc", {16'd0, acc_o}, 32'd14);
    end
    seq_start = 1'b1;

    // Reset in WAIT (cycle 8) after a partial sequence has built up acc.
    send_pair(8'd2, 8'd2, 1'b0, 16'd4, 1'b0);
    @(negedge clk);
    a_i = 8'd3; b_i = 8'd3; last_i = 1'b0; valid_i = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      valid_i = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, ready_o}, 32'd1);
    check("mid_rst_acc", {16'd0, acc_o}, 32'd0);
    check("mid_rst_ovf", {31'd0, ovf_o}, 32'd0);
    check("mid_rst_start", {31'd0, mul_start_o}, 32'd0);
    check("mid_rst_mul_a", {24'd0, mul_a_o}, 32'd0);
    seq_start = 1'b1;
    send_pair(8'd0, 8'd200, 1'b1, 16'd0, 1'b0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
